// File: rtl/axis_width_pkg.sv
// Shared constants and helpers for the 8<->32 AXI-Stream width converters.
// Byte lanes are MSB-first: the first byte of a word sits in tdata[31:24].
package axis_width_pkg;

    localparam int AXIS_BYTE_W = 8;
    localparam int AXIS_WORD_W = 32;
    localparam int AXIS_KEEP_W = 4;

    // Accumulator fill level doubles as the packing state.
    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_B1    = 2'd1;
    localparam logic [1:0] CNT_B2    = 2'd2;
    localparam logic [1:0] CNT_B3    = 2'd3;

    // MSB-aligned contiguous byte enables for a word completed with cnt bytes
    // already held in the accumulator (the completing byte is included).
    function automatic logic [AXIS_KEEP_W-1:0] keep_from_cnt(input logic [1:0] cnt);
        logic [AXIS_KEEP_W-1:0] keep;
        case (cnt)
            CNT_EMPTY: keep = 4'b1000;
            CNT_B1:    keep = 4'b1100;
            CNT_B2:    keep = 4'b1110;
            default:   keep = 4'b1111;
        endcase
        return keep;
    endfunction

endpackage

// File: rtl/axis8to32.sv
// 8-bit to 32-bit AXI-Stream width up-converter with tkeep/tlast.
// Bytes are packed MSB-first; a tlast byte flushes a partial word with
// zero padding in the unused low lanes.
// Optional feature: define AXIS8TO32_PKT_LEN_EN to get a per-packet byte
// count (pkt_len_out) with a one-cycle strobe (pkt_len_valid).
module axis8to32
    import axis_width_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [AXIS_BYTE_W-1:0] axis_tdata_in,
    input  logic                   axis_tvalid_in,
    input  logic                   axis_tlast_in,
    output logic                   axis_tready_out,
    output logic [AXIS_WORD_W-1:0] axis_tdata_out,
    output logic [AXIS_KEEP_W-1:0] axis_tkeep_out,
    output logic                   axis_tvalid_out,
    output logic                   axis_tlast_out,
    input  logic                   axis_tready_in,
    output logic [LEN_W-1:0]       pkt_len_out,
    output logic                   pkt_len_valid
);

    logic [23:0]            accData_q, accData_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [AXIS_WORD_W-1:0] tdata_q, tdata_d;
    logic [AXIS_KEEP_W-1:0] tkeep_q, tkeep_d;
    logic                   tlast_q, tlast_d;
    logic                   tvalid_q, tvalid_d;

    logic                   accept;
    logic                   complete;
    logic [AXIS_WORD_W-1:0] word;
    logic [AXIS_WORD_W-1:0] mask;
    logic [AXIS_KEEP_W-1:0] keepNext;

    // Input is blocked whenever a word is stalled at the output, regardless
    // of whether the offered byte would complete a word.
    assign axis_tready_out = ~tvalid_q | axis_tready_in;
    assign accept          = axis_tvalid_in & axis_tready_out;
    assign complete        = accept & ((cnt_q == CNT_B3) | axis_tlast_in);

    // Next-state: pack accepted bytes, load the output word on completion.
    always_comb begin
        accData_d = accData_q;
        cnt_d     = cnt_q;
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        tlast_d   = tlast_q;
        tvalid_d  = tvalid_q & ~axis_tready_in;

        keepNext = keep_from_cnt(cnt_q);
        word     = {accData_q, 8'h00};
        word[{2'd3 - cnt_q, 3'b000} +: AXIS_BYTE_W] = axis_tdata_in;
        mask = '0;
        for (int i = 0; i < AXIS_KEEP_W; i++) begin
            mask[i*AXIS_BYTE_W +: AXIS_BYTE_W] = {AXIS_BYTE_W{keepNext[i]}};
        end

        if (complete) begin
            tdata_d   = word & mask;
            tkeep_d   = keepNext;
            tlast_d   = axis_tlast_in;
            tvalid_d  = 1'b1;
            accData_d = '0;
            cnt_d     = CNT_EMPTY;
        end else if (accept) begin
            accData_d[{2'd2 - cnt_q, 3'b000} +: AXIS_BYTE_W] = axis_tdata_in;
            cnt_d = cnt_q + 2'd1;
        end
    end

    // State registers; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            accData_q <= '0;
            cnt_q     <= CNT_EMPTY;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tlast_q   <= 1'b0;
            tvalid_q  <= 1'b0;
        end else begin
            accData_q <= accData_d;
            cnt_q     <= cnt_d;
            tdata_q   <= tdata_d;
            tkeep_q   <= tkeep_d;
            tlast_q   <= tlast_d;
            tvalid_q  <= tvalid_d;
        end
    end

    assign axis_tdata_out  = tdata_q;
    assign axis_tkeep_out  = tkeep_q;
    assign axis_tlast_out  = tlast_q;
    assign axis_tvalid_out = tvalid_q;

`ifdef AXIS8TO32_PKT_LEN_EN
    logic [LEN_W-1:0] lenCnt_q;
    logic [LEN_W-1:0] pktLen_q;
    logic             pktLenValid_q;

    // Saturating byte counter; the strobe lines up with the tail word load.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lenCnt_q      <= '0;
            pktLen_q      <= '0;
            pktLenValid_q <= 1'b0;
        end else begin
            pktLenValid_q <= 1'b0;
            if (accept) begin
                if (axis_tlast_in) begin
                    pktLen_q      <= (lenCnt_q == '1) ? lenCnt_q : lenCnt_q + LEN_W'(1);
                    pktLenValid_q <= 1'b1;
                    lenCnt_q      <= '0;
                end else if (lenCnt_q != '1) begin
                    lenCnt_q <= lenCnt_q + LEN_W'(1);
                end
            end
        end
    end

    assign pkt_len_out   = pktLen_q;
    assign pkt_len_valid = pktLenValid_q;
`else
    assign pkt_len_out   = '0;
    assign pkt_len_valid = 1'b0;
`endif

endmodule

// File: tb/tb_axis8to32.sv
// Self-checking bench for axis8to32: directed cases plus randomized packets
// and handshakes, checked against a packet-level reference model.
module tb_axis8to32;

    localparam int LEN_W = 16;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic             clk;
    logic             reset_n;
    logic [7:0]       axis_tdata_in;
    logic             axis_tvalid_in;
    logic             axis_tlast_in;
    logic             axis_tready_out;
    logic [31:0]      axis_tdata_out;
    logic [3:0]       axis_tkeep_out;
    logic             axis_tvalid_out;
    logic             axis_tlast_out;
    logic             axis_tready_in;
    logic [LEN_W-1:0] pkt_len_out;
    logic             pkt_len_valid;

    int          checkCount = 0;
    int          errorCount = 0;
    int          cycleCount = 0;
    int          acceptedBytes = 0;
    int          readyMode = 0;
    word_t       expQ[$];
    int          expLenQ[$];
    logic [7:0]  curPkt[$];
    logic        stallValid = 1'b0;
    word_t       stallWord;

    axis8to32 #(.LEN_W(LEN_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .axis_tdata_in   (axis_tdata_in),
        .axis_tvalid_in  (axis_tvalid_in),
        .axis_tlast_in   (axis_tlast_in),
        .axis_tready_out (axis_tready_out),
        .axis_tdata_out  (axis_tdata_out),
        .axis_tkeep_out  (axis_tkeep_out),
        .axis_tvalid_out (axis_tvalid_out),
        .axis_tlast_out  (axis_tlast_out),
        .axis_tready_in  (axis_tready_in),
        .pkt_len_out     (pkt_len_out),
        .pkt_len_valid   (pkt_len_valid)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for throughput and timeout bounds.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Downstream ready: 0 = always ready, 1 = stalled, 2 = random.
    initial begin
        axis_tready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       axis_tready_in = 1'b1;
                1:       axis_tready_in = 1'b0;
                default: axis_tready_in = ($urandom_range(99) < 80);
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at cycle %0d",
                     tag, observed, expected, cycleCount);
        end
    endtask

    // Reference model: a packet of n bytes becomes ceil(n/4) words, each
    // filled MSB-first, zero padded, keep covering the real bytes.
    task automatic modelPush();
        int n;
        n = curPkt.size();
        for (int w = 0; w < n; w += 4) begin
            word_t ew;
            int k;
            k = (n - w >= 4) ? 4 : n - w;
            ew = '0;
            for (int j = 0; j < k; j++) begin
                ew.data[31 - 8*j -: 8] = curPkt[w + j];
                ew.keep[3 - j] = 1'b1;
            end
            ew.last = (w + 4 >= n);
            expQ.push_back(ew);
        end
        expLenQ.push_back(n);
    endtask

    // Present one byte (after optional idle cycles) and hold it until taken.
    task automatic sendByte(input logic [7:0] b, input logic last, input int gapPct);
        int guard;
        logic got;
        while ($urandom_range(99) < gapPct) begin
            axis_tvalid_in = 1'b0;
            @(posedge clk);
            #1;
        end
        axis_tdata_in  = b;
        axis_tlast_in  = last;
        axis_tvalid_in = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            got = axis_tready_out;
            @(posedge clk);
            #1;
            guard++;
        end while (!got && guard < 2000);
        if (!got) checkOutput("accept_timeout", {31'd0, got}, 32'd1);
        axis_tvalid_in = 1'b0;
        axis_tlast_in  = 1'b0;
    endtask

    // Send the packet held in curPkt, registering it with the model first.
    task automatic applyStimulus(input int gapPct);
        modelPush();
        for (int i = 0; i < curPkt.size(); i++) begin
            sendByte(curPkt[i], (i == curPkt.size() - 1), gapPct);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until every expected word has left the DUT.
    task automatic waitDrain();
        int guard;
        guard = 0;
        while ((expQ.size() != 0 || axis_tvalid_out) && guard < 2000) begin
            waitCycles(1);
            guard++;
        end
        checkOutput("drain_empty", expQ.size(), 0);
    endtask

    task automatic checkResetState();
        checkOutput("rst_tvalid", {31'd0, axis_tvalid_out}, 32'd0);
        checkOutput("rst_tdata",  axis_tdata_out, 32'd0);
        checkOutput("rst_tkeep",  {28'd0, axis_tkeep_out}, 32'd0);
        checkOutput("rst_tlast",  {31'd0, axis_tlast_out}, 32'd0);
        checkOutput("rst_tready", {31'd0, axis_tready_out}, 32'd1);
        checkOutput("rst_pktlen", {16'd0, pkt_len_out}, 32'd0);
        checkOutput("rst_pktval", {31'd0, pkt_len_valid}, 32'd0);
    endtask

    // Output monitor: scoreboard transfers, hold-stability and ready rule.
    always @(negedge clk) begin
        if (!reset_n) begin
            stallValid = 1'b0;
        end else begin
            checkOutput("ready_rule", {31'd0, axis_tready_out},
                        {31'd0, ~axis_tvalid_out | axis_tready_in});
            if (axis_tvalid_in && axis_tready_out) acceptedBytes++;
            if (stallValid) begin
                checkOutput("hold_valid", {31'd0, axis_tvalid_out}, 32'd1);
                checkOutput("hold_data", axis_tdata_out, stallWord.data);
                checkOutput("hold_keep", {28'd0, axis_tkeep_out}, {28'd0, stallWord.keep});
                checkOutput("hold_last", {31'd0, axis_tlast_out}, {31'd0, stallWord.last});
            end
            if (axis_tvalid_out && axis_tready_in) begin
                if (expQ.size() == 0) begin
                    checkOutput("word_unexpected", expQ.size(), 1);
                end else begin
                    word_t ew;
                    ew = expQ.pop_front();
                    checkOutput("word_data", axis_tdata_out, ew.data);
                    checkOutput("word_keep", {28'd0, axis_tkeep_out}, {28'd0, ew.keep});
                    checkOutput("word_last", {31'd0, axis_tlast_out}, {31'd0, ew.last});
                end
            end
            stallValid     = axis_tvalid_out && !axis_tready_in;
            stallWord.data = axis_tdata_out;
            stallWord.keep = axis_tkeep_out;
            stallWord.last = axis_tlast_out;
`ifdef AXIS8TO32_PKT_LEN_EN
            if (pkt_len_valid) begin
                checkOutput("pktlen_with_valid", {31'd0, axis_tvalid_out}, 32'd1);
                if (expLenQ.size() == 0) begin
                    checkOutput("pktlen_unexpected", expLenQ.size(), 1);
                end else begin
                    checkOutput("pktlen_value", {16'd0, pkt_len_out}, expLenQ.pop_front());
                end
            end
`endif
        end
    end

    // Overall time bound.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    // Main sequence.
    initial begin
        int startCycle;
        int startBytes;
        reset_n        = 1'b0;
        axis_tdata_in  = 8'h00;
        axis_tvalid_in = 1'b0;
        axis_tlast_in  = 1'b0;
        readyMode      = 0;
        waitCycles(3);
        reset_n = 1'b1;
        @(negedge clk);
        checkResetState();
        waitCycles(1);

        $display("[TB] 8-byte packet, no stalls");
        curPkt = {};
        for (int i = 1; i <= 8; i++) curPkt.push_back(8'(i));
        startCycle = cycleCount;
        applyStimulus(0);
        checkOutput("throughput_8", cycleCount - startCycle, 8);
        waitDrain();

        $display("[TB] 5-byte packet with partial tail");
        curPkt = {};
        for (int i = 0; i < 5; i++) curPkt.push_back(8'hA0 + 8'(i));
        applyStimulus(0);
        waitDrain();

        $display("[TB] single-byte packet latency");
        curPkt = {8'h5A};
        modelPush();
        sendByte(8'h5A, 1'b1, 0);
        checkOutput("single_valid", {31'd0, axis_tvalid_out}, 32'd1);
        checkOutput("single_data", axis_tdata_out, 32'h5A000000);
        checkOutput("single_keep", {28'd0, axis_tkeep_out}, 32'h8);
        waitDrain();

        $display("[TB] output backpressure");
        readyMode  = 1;
        startBytes = acceptedBytes;
        curPkt = {};
        for (int i = 0; i < 8; i++) curPkt.push_back(8'h21 + 8'(i));
        fork
            applyStimulus(0);
        join_none
        waitCycles(12);
        checkOutput("bp_valid", {31'd0, axis_tvalid_out}, 32'd1);
        checkOutput("bp_data", axis_tdata_out, 32'h21222324);
        checkOutput("bp_ready", {31'd0, axis_tready_out}, 32'd0);
        checkOutput("bp_accepted", acceptedBytes - startBytes, 4);
        readyMode = 0;
        wait fork;
        waitDrain();

        $display("[TB] reset mid-packet");
        sendByte(8'hEE, 1'b0, 0);
        sendByte(8'hEF, 1'b0, 0);
        reset_n = 1'b0;
        waitCycles(1);
        reset_n = 1'b1;
        @(negedge clk);
        checkResetState();
        waitCycles(1);
        curPkt = {8'h11, 8'h12, 8'h13, 8'h14};
        applyStimulus(0);
        waitDrain();

        $display("[TB] random packets");
        readyMode = 2;
        for (int p = 0; p < 1000; p++) begin
            int len;
            len = $urandom_range(64, 1);
            curPkt = {};
            for (int i = 0; i < len; i++) curPkt.push_back(8'($urandom));
            applyStimulus(20);
        end
        waitDrain();
        readyMode = 0;
        waitCycles(2);
`ifdef AXIS8TO32_PKT_LEN_EN
        checkOutput("pktlen_all_seen", expLenQ.size(), 0);
`else
        checkOutput("pktlen_tied", {16'd0, pkt_len_out}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
